// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/subtract: stage 1 forms the raw W+1-bit sum or difference,
// stage 2 folds it back into [0, Q). A single advance enable gives backpressure to all stages.
module mod_addsub_pipe #(
  parameter int W = 384,
  parameter logic [W-1:0] Q = 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [M-1:0] m_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out0,
  output logic [M-1:0] m_o,
  output logic         range_err
);

  logic         en;
  logic         v1;
  logic         op1;
  logic [M-1:0] m1;
  logic [W:0]   r1;
  logic [W:0]   raw;
  logic [W-1:0] red;
  logic         oor;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign raw = op ? ({1'b0, in0} - {1'b0, in1}) : ({1'b0, in0} + {1'b0, in1});
  assign oor = (in0 >= Q) || (in1 >= Q);

  // Bit W of r1 is the carry for add and the borrow for sub; only the low W bits of r-Q
  // or r+Q survive, so the correction is done in W-bit modular arithmetic.
  always_comb begin
    red = r1[W-1:0];
    if (!op1) begin
      if (r1 >= {1'b0, Q}) red = r1[W-1:0] - Q;
    end else begin
      if (r1[W]) red = r1[W-1:0] + Q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      op1 <= 1'b0;
      m1  <= '0;
      r1  <= '0;
    end else if (en) begin
      v1  <= in_valid;
      op1 <= op;
      m1  <= m_i;
      r1  <= raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out0      <= '0;
      m_o       <= '0;
    end else if (en) begin
      out_valid <= v1;
      out0      <= red;
      m_o       <= m1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (in_valid && en && oor) begin
      range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe at W=8, Q=251: directed boundary vectors, full-rate and
// backpressured streams against a modular golden model, sticky range flag, async reset.
module tb_mod_addsub_pipe;
  localparam int W = 8;
  localparam int M = 4;
  localparam int QI = 251;
  localparam logic [W-1:0] Q = 8'd251;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic [M-1:0] m_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out0;
  logic [M-1:0] m_o;
  logic         range_err;

  int errors = 0;
  int checks = 0;

  mod_addsub_pipe #(.W(W), .Q(Q), .M(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in0(in0), .in1(in1), .m_i(m_i), .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .m_o(m_o), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic op;
    int   a;
    int   b;
    int   exp;
  } vec_t;

  vec_t vecs[7] = '{
    '{1'b0, 200, 100, 49},
    '{1'b0, 250, 250, 249},
    '{1'b0,   1, 250, 0},
    '{1'b1,   5,  10, 246},
    '{1'b1,   7,   7, 0},
    '{1'b1,   0, 250, 1},
    '{1'b1, 250,   0, 250}
  };

  task automatic run_stream(input int n, input int duty, output int cycles);
    int exp_q[$];
    int tag_q[$];
    int sent, got, a, b, e;
    logic stalled;
    logic [W-1:0] held_o;
    logic [M-1:0] held_m;
    sent = 0; got = 0; cycles = 0; stalled = 1'b0; held_o = '0; held_m = '0;
    while (got < n && cycles < 3000) begin
      out_ready = ($urandom_range(0, 99) < duty);
      if (sent < n) begin
        in_valid = 1'b1;
        op  = $urandom_range(0, 1) == 1;
        in0 = W'($urandom_range(0, QI - 1));
        in1 = W'($urandom_range(0, QI - 1));
        m_i = M'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #4;
      if (stalled) begin
        check("hold_out0", int'(out0), int'(held_o));
        check("hold_tag", int'(m_o), int'(held_m));
      end
      if (out_valid) check("in_ready_track", int'(in_ready), int'(out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          check("stream_out0", int'(out0), exp_q.pop_front());
          check("stream_tag", int'(m_o), tag_q.pop_front());
          got++;
        end
      end
      stalled = out_valid && !out_ready;
      held_o = out0;
      held_m = m_o;
      if (in_valid && in_ready) begin
        a = int'(in0);
        b = int'(in1);
        e = op ? (a - b + QI) % QI : (a + b) % QI;
        exp_q.push_back(e);
        tag_q.push_back(sent % (1 << M));
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out0", int'(out0), 0);
    check("rst_m_o", int'(m_o), 0);
    check("rst_range_err", int'(range_err), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Directed vectors, one at a time, 2-cycle latency.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; op = vecs[i].op;
      in0 = W'(vecs[i].a); in1 = W'(vecs[i].b); m_i = M'(i + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_early_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      check("dir_valid", int'(out_valid), 1);
      check("dir_out0", int'(out0), vecs[i].exp);
      check("dir_tag", int'(m_o), i + 1);
      @(posedge clk); #1;
    end
    check("no_range_err", int'(range_err), 0);

    run_stream(50, 100, cyc);
    check("full_rate_cycles", cyc, 52);
    run_stream(200, 50, cyc);
    @(posedge clk); #1;
    check("drained_valid", int'(out_valid), 0);

    // Sticky range flag.
    in_valid = 1'b1; op = 1'b0; in0 = 8'd251; in1 = 8'd0; m_i = '0;
    @(posedge clk); #1;
    check("range_err_set", int'(range_err), 1);
    in0 = 8'd3; in1 = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("range_err_sticky", int'(range_err), 1);
    check("after_bad_out0", int'(out0), 7);
    @(posedge clk); #1;

    // Async reset with two ops in flight and the output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; in0 = 8'd10; in1 = 8'd20; m_i = 4'd5;
    @(posedge clk); #1;
    in0 = 8'd30; in1 = 8'd40; m_i = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", int'(out_valid), 1);
    check("pre_rst_out0", int'(out0), 30);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out0", int'(out0), 0);
    check("arst_m_o", int'(m_o), 0);
    check("arst_range_err", int'(range_err), 0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_out", int'(out_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
